// File: rtl/bus_trace_pkg.sv
// Shared types for the bus trace buffer: capture FSM states, default geometry and the trace entry layout.
package bus_trace_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 64;
  localparam int DEF_TS_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Entry layout at the default geometry; the top rebuilds it from its own parameters.
  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0]   ts;
    logic                      is_write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } trace_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// A read and a write of the same slot in one cycle return the old contents.
module trace_ram
  import bus_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 55,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/bus_trace_buffer.sv
// Passive snooper of the CPU<->data-memory bus: timestamps writes and read responses into a
// circular trace RAM, with arm / address trigger / post-trigger count control and indexed readout.
module bus_trace_buffer
  import bus_trace_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  MEM_DEPTH   = 64,
  parameter int  TRACE_DEPTH = 16,
  parameter int  TS_WIDTH    = 16,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH),
  localparam int IDX_W       = $clog2(TRACE_DEPTH),
  localparam int ENTRY_W     = TS_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mon_req_valid,
  input  logic                  mon_we,
  input  logic [ADDR_WIDTH-1:0] mon_addr,
  input  logic [DATA_WIDTH-1:0] mon_wdata,
  input  logic                  mon_valid_data,
  input  logic [DATA_WIDTH-1:0] mon_rdata,
  input  logic                  arm,
  input  logic                  stop_on_full,
  input  logic                  trig_en,
  input  logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic [IDX_W:0]        post_count,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [ENTRY_W-1:0]    rd_entry,
  output logic [IDX_W:0]        count,
  output logic                  capturing,
  output logic                  done,
  output logic [7:0]            drop_cnt
);

  localparam logic [IDX_W:0]      FULL_CNT = (IDX_W+1)'(TRACE_DEPTH);
  localparam logic [IDX_W:0]      LAST_CNT = (IDX_W+1)'(TRACE_DEPTH - 1);
  localparam logic [IDX_W:0]      CNT_ZERO = (IDX_W+1)'(0);
  localparam logic [IDX_W:0]      CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0]    PTR_ONE  = IDX_W'(1);
  localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]        count_q, count_d;
  logic [IDX_W:0]        rem_q, rem_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [7:0]            drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  cfg_stop_q, cfg_stop_d;
  logic                  cfg_trig_q, cfg_trig_d;
  logic [ADDR_WIDTH-1:0] cfg_taddr_q, cfg_taddr_d;
  logic [IDX_W:0]        cfg_post_q, cfg_post_d;
  logic                  rd_valid_q, rd_oob_q;

  logic                  ev_w, ev_r, accept, store, full_hit, trig_hit;
  logic [ADDR_WIDTH-1:0] ev_addr;
  entry_t                ev_entry;
  logic [IDX_W-1:0]      rd_phys;
  logic [ENTRY_W-1:0]    ram_rdata;

  // A write wins over a simultaneous read response; the read response is the dropped one.
  always_comb begin
    ev_w              = mon_req_valid & mon_we;
    ev_r              = mon_valid_data;
    ev_addr           = ev_w ? mon_addr : pend_addr_q;
    ev_entry.ts       = ts_q;
    ev_entry.is_write = ev_w;
    ev_entry.addr     = ev_addr;
    ev_entry.data     = ev_w ? mon_wdata : mon_rdata;
    accept            = (state_q == ARMED) || ((state_q == POST) && (rem_q != CNT_ZERO));
    store             = ~arm & accept & (ev_w | ev_r);
    full_hit          = (count_q == LAST_CNT);
    trig_hit          = cfg_trig_q & (ev_addr == cfg_taddr_q);
    rd_phys           = (count_q == FULL_CNT) ? (wr_ptr_q + rd_idx) : rd_idx;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rem_d       = rem_q;
    ts_d        = ts_q + TS_ONE;
    drop_d      = drop_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_trig_d  = cfg_trig_q;
    cfg_taddr_d = cfg_taddr_q;
    cfg_post_d  = cfg_post_q;
    if (mon_req_valid && !mon_we) begin
      pend_addr_d = mon_addr;
    end else begin
      pend_addr_d = pend_addr_q;
    end

    if (arm) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      count_d     = CNT_ZERO;
      rem_d       = CNT_ZERO;
      ts_d        = '0;
      drop_d      = 8'd0;
      cfg_stop_d  = stop_on_full;
      cfg_trig_d  = trig_en;
      cfg_taddr_d = trig_addr;
      cfg_post_d  = post_count;
    end else begin
      if (store) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = (count_q == FULL_CNT) ? count_q : count_q + CNT_ONE;
        drop_d   = (ev_w && ev_r) ? sat_inc8(drop_q) : drop_q;
      end else begin
        count_d = count_q;
      end
      // rem==0 in POST means the post-trigger window is already filled, so nothing more is stored.
      case (state_q)
        ARMED: begin
          if (store && cfg_stop_q && full_hit) begin
            state_d = DONE;
          end else if (store && trig_hit) begin
            state_d = POST;
            rem_d   = cfg_post_q;
          end else begin
            state_d = ARMED;
          end
        end
        POST: begin
          if (rem_q == CNT_ZERO) begin
            state_d = DONE;
          end else if (store) begin
            rem_d   = rem_q - CNT_ONE;
            state_d = ((rem_q == CNT_ONE) || (cfg_stop_q && full_hit)) ? DONE : POST;
          end else begin
            state_d = POST;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= CNT_ZERO;
      rem_q       <= CNT_ZERO;
      ts_q        <= '0;
      drop_q      <= 8'd0;
      pend_addr_q <= '0;
      cfg_stop_q  <= 1'b0;
      cfg_trig_q  <= 1'b0;
      cfg_taddr_q <= '0;
      cfg_post_q  <= CNT_ZERO;
      rd_valid_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      ts_q        <= ts_d;
      drop_q      <= drop_d;
      pend_addr_q <= pend_addr_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_trig_q  <= cfg_trig_d;
      cfg_taddr_q <= cfg_taddr_d;
      cfg_post_q  <= cfg_post_d;
      rd_valid_q  <= rd_en;
      rd_oob_q    <= ({1'b0, rd_idx} >= count_q);
    end
  end

  trace_ram #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (ev_entry),
    .re_i    (rd_en),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_entry  = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;
  assign count     = count_q;
  assign capturing = (state_q == ARMED) || (state_q == POST);
  assign done      = (state_q == DONE);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Scoreboard bench for bus_trace_buffer: directed scenarios plus random traffic against a
// queue-based reference model of the trace contents and capture state.
module tb_bus_trace_buffer;

  localparam int DW  = 32;
  localparam int MD  = 64;
  localparam int TD  = 16;
  localparam int TSW = 16;
  localparam int AW  = $clog2(MD);
  localparam int IW  = $clog2(TD);
  localparam int EW  = TSW + 1 + AW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, mon_req_valid, mon_we, mon_valid_data, arm, stop_on_full, trig_en, rd_en;
  logic [AW-1:0] mon_addr, trig_addr;
  logic [DW-1:0] mon_wdata, mon_rdata;
  logic [IW:0]   post_count;
  logic [IW-1:0] rd_idx;
  logic          rd_valid, capturing, done;
  logic [EW-1:0] rd_entry;
  logic [IW:0]   count;
  logic [7:0]    drop_cnt;

  bus_trace_buffer #(
    .DATA_WIDTH (DW), .MEM_DEPTH (MD), .TRACE_DEPTH (TD), .TS_WIDTH (TSW)
  ) dut (
    .clk (clk), .reset (reset),
    .mon_req_valid (mon_req_valid), .mon_we (mon_we), .mon_addr (mon_addr), .mon_wdata (mon_wdata),
    .mon_valid_data (mon_valid_data), .mon_rdata (mon_rdata),
    .arm (arm), .stop_on_full (stop_on_full), .trig_en (trig_en), .trig_addr (trig_addr),
    .post_count (post_count), .rd_en (rd_en), .rd_idx (rd_idx),
    .rd_valid (rd_valid), .rd_entry (rd_entry), .count (count),
    .capturing (capturing), .done (done), .drop_cnt (drop_cnt)
  );

  // Reference model: trace_q holds the retained entries, oldest first (at most TD of them).
  logic [EW-1:0]  trace_q[$];
  logic [EW-1:0]  exp_q[$];
  logic           m_cap, m_done, m_in_post, m_stop, m_trig, m_fresh_reset;
  logic [AW-1:0]  m_taddr, m_pend;
  logic [TSW-1:0] m_ts;
  int             m_post, m_rem, m_drop;
  bit             m_started = 1'b0;
  bit             tb_end    = 1'b0;
  int             checks    = 0;
  int             errors    = 0;

  task automatic finish_capture();
    m_cap  = 1'b0;
    m_done = 1'b1;
  endtask

  task automatic model_step();
    logic          ev_w, ev_r, full;
    logic [AW-1:0] ea;
    if (reset) begin
      trace_q.delete();
      m_cap = 1'b0; m_done = 1'b0; m_in_post = 1'b0; m_stop = 1'b0; m_trig = 1'b0;
      m_taddr = '0; m_pend = '0; m_ts = '0; m_post = 0; m_rem = 0; m_drop = 0;
      m_fresh_reset = 1'b1;
      return;
    end
    ev_w = mon_req_valid && mon_we;
    ev_r = mon_valid_data;
    if (arm) begin
      trace_q.delete();
      m_drop = 0; m_cap = 1'b1; m_done = 1'b0; m_in_post = 1'b0; m_rem = 0;
      m_stop = stop_on_full; m_trig = trig_en; m_taddr = trig_addr; m_post = int'(post_count);
    end else if (m_cap && m_in_post && m_rem == 0) begin
      finish_capture();
    end else if (m_cap && (ev_w || ev_r)) begin
      ea = ev_w ? mon_addr : m_pend;
      trace_q.push_back(ev_w ? {m_ts, 1'b1, mon_addr, mon_wdata} : {m_ts, 1'b0, m_pend, mon_rdata});
      if (trace_q.size() > TD) void'(trace_q.pop_front());
      if (ev_w && ev_r && m_drop < 255) m_drop++;
      full = m_stop && (trace_q.size() == TD);
      if (!m_in_post) begin
        if (full) finish_capture();
        else if (m_trig && ea == m_taddr) begin
          m_in_post = 1'b1;
          m_rem     = m_post;
        end
      end else begin
        m_rem--;
        if (m_rem == 0 || full) finish_capture();
      end
    end
    if (mon_req_valid && !mon_we) m_pend = mon_addr;
    m_ts = arm ? '0 : m_ts + 1'b1;
  endtask

  // One clock: expected readout is taken from the model before this edge's update.
  task automatic tick();
    bit            push;
    logic [EW-1:0] e;
    push = rd_en && !reset;
    e    = '0;
    if (push && int'(rd_idx) < trace_q.size()) e = trace_q[rd_idx];
    @(posedge clk);
    if (push) begin
      exp_q.push_back(e);
      m_fresh_reset = 1'b0;
    end
    model_step();
    m_started = 1'b1;
    #1;
    mon_req_valid = 1'b0; mon_we = 1'b0; mon_valid_data = 1'b0;
    arm = 1'b0; rd_en = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic do_arm(input bit stop, input bit ten, input int taddr, input int pc);
    arm = 1'b1; stop_on_full = stop; trig_en = ten;
    trig_addr = AW'(taddr); post_count = (IW+1)'(pc);
    tick();
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    mon_req_valid = 1'b1; mon_we = 1'b1; mon_addr = AW'(a); mon_wdata = d;
    tick();
  endtask

  task automatic read_all();
    for (int i = 0; i < TD; i++) begin
      rd_en  = 1'b1;
      rd_idx = IW'(i);
      tick();
    end
  endtask

  // Stimulus
  initial begin
    reset = 1'b1; mon_req_valid = 1'b0; mon_we = 1'b0; mon_addr = '0; mon_wdata = '0;
    mon_valid_data = 1'b0; mon_rdata = '0; arm = 1'b0; stop_on_full = 1'b0; trig_en = 1'b0;
    trig_addr = '0; post_count = '0; rd_en = 1'b0; rd_idx = '0;
    do_reset();
    do_reset();
    read_all();

    // wrap mode, three writes
    do_arm(1'b0, 1'b0, 0, 0);
    do_write(5, 32'hA0); do_write(6, 32'hA1); do_write(7, 32'hA2);
    tick();
    read_all();

    // stop at full after 16 of 20 writes
    do_arm(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) do_write(i + 1, 32'hB000 + 32'(i));
    read_all();

    // wrap mode keeps the newest 16 of 20
    do_arm(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) do_write(i, 32'hD000 + 32'(i));
    read_all();

    // trigger on 9 with two post entries
    do_arm(1'b0, 1'b1, 9, 2);
    do_write(1, 32'h11); do_write(9, 32'h99); do_write(2, 32'h22);
    do_write(3, 32'h33); do_write(4, 32'h44);
    tick(); tick();
    read_all();

    // read response attributed to pending address, then W/R collision
    do_arm(1'b0, 1'b0, 0, 0);
    mon_req_valid = 1'b1; mon_we = 1'b0; mon_addr = AW'(12); tick();
    mon_valid_data = 1'b1; mon_rdata = 32'hCAFE; tick();
    mon_req_valid = 1'b1; mon_we = 1'b0; mon_addr = AW'(20); tick();
    mon_req_valid = 1'b1; mon_we = 1'b1; mon_addr = AW'(30); mon_wdata = 32'h3030;
    mon_valid_data = 1'b1; mon_rdata = 32'hBEEF; tick();
    read_all();

    // post_count 0: only the trigger entry survives
    do_arm(1'b0, 1'b1, 5, 0);
    do_write(5, 32'h55); do_write(6, 32'h66); do_write(7, 32'h77);
    read_all();

    // re-arm in POST with a write in the arm cycle, then reset mid-capture
    do_arm(1'b0, 1'b1, 3, 10);
    do_write(1, 32'h1); do_write(3, 32'h3); do_write(4, 32'h4);
    mon_req_valid = 1'b1; mon_we = 1'b1; mon_addr = AW'(8); mon_wdata = 32'h8;
    do_arm(1'b0, 1'b0, 0, 0);
    tick();
    do_write(2, 32'h2);
    do_reset();
    tick(); tick();
    read_all();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      mon_req_valid  = 1'($urandom_range(0, 1));
      mon_we         = 1'($urandom_range(0, 1));
      mon_addr       = AW'($urandom_range(0, 15));
      mon_wdata      = $urandom;
      mon_valid_data = ($urandom_range(0, 2) == 0);
      mon_rdata      = $urandom;
      rd_en          = 1'($urandom_range(0, 1));
      rd_idx         = IW'($urandom_range(0, TD - 1));
      stop_on_full   = 1'($urandom_range(0, 1));
      trig_en        = 1'($urandom_range(0, 1));
      trig_addr      = AW'($urandom_range(0, 15));
      post_count     = (IW+1)'($urandom_range(0, TD));
      arm            = ($urandom_range(0, 59) == 0);
      reset          = ($urandom_range(0, 399) == 0);
      tick();
    end
    read_all();
    tick();
    tb_end = 1'b1;
  end

  // Monitor: compares DUT outputs against the model on every falling edge.
  initial begin
    logic [IW:0]   e_count;
    logic [7:0]    e_drop;
    logic [EW-1:0] e_ent;
    forever begin
      @(negedge clk);
      if (m_started) begin
        e_count = (IW+1)'(trace_q.size());
        e_drop  = 8'(m_drop);
        checks++;
        if (count !== e_count || capturing !== m_cap || done !== m_done || drop_cnt !== e_drop) begin
          errors++;
          $display("FAIL status t=%0t: got count=%0d capturing=%0b done=%0b drop=%0d, want count=%0d capturing=%0b done=%0b drop=%0d",
                   $time, count, capturing, done, drop_cnt, e_count, m_cap, m_done, e_drop);
        end
        checks++;
        if (rd_valid !== (exp_q.size() != 0)) begin
          errors++;
          $display("FAIL rd_valid t=%0t: got %0b, want %0b", $time, rd_valid, exp_q.size() != 0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (rd_valid) begin
          e_ent = exp_q.pop_front();
          checks++;
          if (rd_entry !== e_ent) begin
            errors++;
            $display("FAIL rd_entry t=%0t: got %h, want %h", $time, rd_entry, e_ent);
          end
        end else if (m_fresh_reset) begin
          checks++;
          if (rd_entry !== '0) begin
            errors++;
            $display("FAIL reset_rd_entry t=%0t: got %h, want 0", $time, rd_entry);
          end
        end
      end
      if (tb_end) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_reads: got %0d outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
